sevenseg_scan_ext: RTL and testbench
====================================

// Module: sevenseg_scan_ext
// PURPOSE
//  Time-multiplexed scan controller for the NDIG-digit common-anode display.
//  Holds one 7-bit extended code per digit: [6]=blank, [5]=dp, [4]=dash, [3:0]=hex.
//  Drives the active-low anode enables, one digit at a time.
//  Feeds the selected code directly into the downstream extended seven-segment decoder (input d).
//  Inserts a blanking guard interval between digits to suppress ghosting.
// PARAMETERS
//  NDIG          8            number of digits scanned (>=2)
//  CLK_FREQ      100_000_000  clk frequency, Hz
//  DIGIT_HZ      1000         dwell rate per digit; TICK_DIV = CLK_FREQ/DIGIT_HZ
//  BLANK_CYCLES  100          guard cycles, all anodes off; 1 <= BLANK_CYCLES < TICK_DIV
// PORTS
//  clk        in   1        system clock; single clock domain
//  rst        in   1        synchronous, active-high reset
//  en         in   1        display enable; low = all digits dark
//  d_ext      in   7*NDIG   digit i code at [7*i+6 : 7*i]
//  ext_out    out  7        code for the active digit -> decoder d
//  an_n       out  NDIG     anode enables, active low, at most one low at a time
//  digit_sel  out  $clog2(NDIG)  index of current digit
// BEHAVIOUR
//  - All outputs are registered. Reset state:
//    state=GUARD, digit_sel=0, an_n='1, ext_out=7'b100_0000 (blank), counters=0.
//  - FSM GUARD:
//    an_n='1, ext_out=blank. guard_cnt counts 0..BLANK_CYCLES-1.
//    At terminal count -> SHOW. On that same edge, latch d_ext slice [digit_sel] into ext_out.
//    Also assert an_n[digit_sel]=0 and clear the prescaler.
//  - FSM SHOW:
//    ext_out is held constant for the whole dwell; d_ext changes mid-dwell are ignored.
//    The prescaler counts 0..TICK_DIV-1. At terminal count -> GUARD.
//    On that edge: an_n='1, ext_out=blank, digit_sel increments. After NDIG-1, digit_sel wraps to 0.
//  - Timing: SHOW lasts exactly TICK_DIV cycles, GUARD exactly BLANK_CYCLES.
//    Full frame = NDIG*(TICK_DIV+BLANK_CYCLES) cycles.
//  - en low, sampled any cycle:
//    next edge forces GUARD with guard_cnt=0, an_n='1, ext_out=blank.
//    digit_sel is retained. Scanning resumes from that digit after en returns high.
//  - rst mid-dwell: returns to reset state on the next edge, regardless of en or state.
//  - rst and en both asserted: rst wins.
//  - Invariant: an_n never has two zeros. ext_out is never non-blank while an_n='1.
// CONFIGURATION
//  Macro SEVENSEG_LZ_BLANK_EN enables leading-zero blanking.
//  - Defined: on entry to SHOW for digit i>0, ext_out is forced to 7'b100_0000 when both hold:
//    d_ext[i] == 7'b000_0000 (plain 0, no dp, no dash), and
//    every digit j>i is plain 0 or has bit6 set.
//    Digit 0 is never blanked. The anode timing is unchanged.
//  - Undefined: the d_ext slice passes through unmodified.
// STRUCTURE
//  - Package sevenseg_pkg holds:
//    typedef struct packed {blank, dp, dash, logic [3:0] hex} ext_code_t;
//    typedef enum logic {GUARD, SHOW} scan_state_t;
//    localparam ext_code_t EXT_BLANK = 7'b100_0000.
//  - Sub-module tick_gen (parameter DIV; inputs clk, rst, clr; output tick) is the prescaler.
//    tick is a one-cycle pulse on count DIV-1.
//  - The leading-zero mask is a combinational function in this file.
// TESTING (NDIG=4, CLK_FREQ=1000, DIGIT_HZ=100 -> TICK_DIV=10, BLANK_CYCLES=2)
//  1. Reset: rst high 3 cycles -> an_n=4'hF, ext_out=7'h40, digit_sel=0.
//     After rst drops, the first anode goes low exactly 2 cycles later.
//  2. Scan order: d_ext = {7'h03, 7'h02, 7'h01, 7'h00} ->
//     an_n steps E,D,B,7 with ext_out 00,01,02,03.
//     Each step has a 10-cycle dwell and a 2-cycle all-F gap. Wrap back to digit 0 at cycle 48.
//  3. Mid-dwell change: change d_ext[1] 5 cycles into digit 1's dwell ->
//     ext_out is unchanged until the next visit to digit 1.
//  4. Enable drop: en=0 during the digit 2 dwell ->
//     next edge an_n=F, ext_out=40. Raise en -> digit 2 is shown after 2 guard cycles.
//  5. Reset mid-operation: rst pulse during the digit 3 dwell ->
//     next edge gives the reset values and digit_sel=0. Checker asserts one-hot-low an_n every cycle.
//  6. SEVENSEG_LZ_BLANK_EN: d_ext = {00, 00, 05, 00} -> digits 3 and 2 are blank; digits 1 and 0 show 05 and 00.
//     Without the macro, all four digits show their codes.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types and constants for the seven-segment scan controller
// Purpose: extended digit code layout, scan FSM states and the blank code.
// Ports: none (package).
package sevenseg_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic       dash;
    logic [3:0] hex;
  } ext_code_t;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam ext_code_t EXT_BLANK = 7'b100_0000;

endpackage

// File: rtl/sevenseg_scan_ext_tick_gen.sv
// rtl/sevenseg_scan_ext_tick_gen.sv - dwell prescaler for the scan controller
// Purpose: free-running modulo-DIV counter with a synchronous clear.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clr   in  holds the count at zero while high
//   tick  out high for the one cycle the count equals DIV-1
module tick_gen
  import sevenseg_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]    LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sevenseg_scan_ext.sv
// rtl/sevenseg_scan_ext.sv - time-multiplexed scan controller for a common-anode display
// Purpose: shows one extended code per digit in turn, with an all-dark guard
//          interval between digits. Optional macro SEVENSEG_LZ_BLANK_EN enables
//          leading-zero blanking of the upper digits.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   display enable, low keeps every digit dark
//   d_ext      in   7*NDIG codes, digit i at [7*i+6:7*i]
//   ext_out    out  registered code of the active digit, feeds the decoder
//   an_n       out  active-low anode enables, at most one low
//   digit_sel  out  index of the current digit
module sevenseg_scan_ext
  import sevenseg_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [7*NDIG-1:0]       d_ext,
  output logic [6:0]              ext_out,
  output logic [NDIG-1:0]         an_n,
  output logic [$clog2(NDIG)-1:0] digit_sel
);

  localparam int               TICK_DIV   = CLK_FREQ / DIGIT_HZ;
  localparam int               SW         = $clog2(NDIG);
  localparam int               GW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [SW-1:0]    LAST_DIG   = SW'(NDIG - 1);
  localparam logic [GW-1:0]    LAST_GUARD = GW'(BLANK_CYCLES - 1);
  localparam logic [NDIG-1:0]  ONE_HOT0   = {{(NDIG-1){1'b0}}, 1'b1};

  scan_state_t     state_q, state_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [NDIG-1:0] an_q, an_d;
  ext_code_t       ext_q, ext_d;
  ext_code_t       sel_code;
  logic            tick;

  // The prescaler only runs during SHOW; holding it clear through every guard
  // cycle guarantees it starts from zero on each SHOW entry.
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == GUARD),
    .tick (tick)
  );

`ifdef SEVENSEG_LZ_BLANK_EN
  // Bit i set when digit i (i>0) is a plain zero and every digit above it is
  // either a plain zero or already blank. Walking downward from the top digit
  // keeps a running "everything above is dark" flag.
  function automatic logic [NDIG-1:0] lz_mask(input logic [7*NDIG-1:0] codes);
    logic [NDIG-1:0] m;
    logic            upper_dark;
    m          = '0;
    upper_dark = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (upper_dark && (codes[7*i +: 7] == 7'b000_0000)) begin
        m[i] = 1'b1;
      end
      upper_dark = upper_dark && ((codes[7*i +: 7] == 7'b000_0000) || codes[7*i+6]);
    end
    return m;
  endfunction

  logic [NDIG-1:0] lz_m;
  assign lz_m = lz_mask(d_ext);

  always_comb begin
    sel_code = d_ext[7*int'(sel_q) +: 7];
    if (lz_m[sel_q]) begin
      sel_code = EXT_BLANK;
    end
  end
`else
  always_comb begin
    sel_code = d_ext[7*int'(sel_q) +: 7];
  end
`endif

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    sel_d   = sel_q;
    an_d    = an_q;
    ext_d   = ext_q;
    if (!en) begin
      // Go dark immediately but keep the digit index so scanning resumes there.
      state_d = GUARD;
      guard_d = '0;
      an_d    = '1;
      ext_d   = EXT_BLANK;
    end else if (state_q == GUARD) begin
      if (guard_q == LAST_GUARD) begin
        state_d = SHOW;
        guard_d = '0;
        an_d    = ~(ONE_HOT0 << sel_q);
        ext_d   = sel_code;
      end else begin
        guard_d = guard_q + 1'b1;
      end
    end else begin
      if (tick) begin
        state_d = GUARD;
        an_d    = '1;
        ext_d   = EXT_BLANK;
        sel_d   = (sel_q == LAST_DIG) ? '0 : sel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GUARD;
      guard_q <= '0;
      sel_q   <= '0;
      an_q    <= '1;
      ext_q   <= EXT_BLANK;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      ext_q   <= ext_d;
    end
  end

  assign ext_out   = ext_q;
  assign an_n      = an_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_sevenseg_scan_ext.sv
// tb/tb_sevenseg_scan_ext.sv - self-checking bench for sevenseg_scan_ext
module tb_sevenseg_scan_ext;

  localparam int NDIG = 4;
  localparam int TD   = 10;
  localparam int BL   = 2;
  localparam int SLOT = TD + BL;

`ifdef SEVENSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [7*NDIG-1:0]       d_ext;
  logic [6:0]              ext_out;
  logic [NDIG-1:0]         an_n;
  logic [$clog2(NDIG)-1:0] digit_sel;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  sevenseg_scan_ext #(
    .NDIG         (NDIG),
    .CLK_FREQ     (1000),
    .DIGIT_HZ     (100),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d_ext     (d_ext),
    .ext_out   (ext_out),
    .an_n      (an_n),
    .digit_sel (digit_sel)
  );

  // Model: position within a digit slot. Slot positions 0..BL-1 are dark,
  // BL..SLOT-1 show the code captured when the slot reached position BL.
  int       m_t   = 0;
  int       m_dig = 0;
  logic [6:0] m_code = 7'h40;

  function automatic logic [6:0] code_of(input int i);
    logic [6:0] c;
    bit         dark_above;
    c = d_ext[7*i +: 7];
    if (LZ && i > 0 && c == 7'h00) begin
      dark_above = 1'b1;
      for (int j = i + 1; j < NDIG; j++) begin
        if (!(d_ext[7*j +: 7] == 7'h00 || d_ext[7*j+6])) dark_above = 1'b0;
      end
      if (dark_above) c = 7'h40;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t   = 0;
      m_dig = 0;
    end else if (!en) begin
      m_t = 0;
    end else if (m_t == SLOT - 1) begin
      m_t   = 0;
      m_dig = (m_dig + 1) % NDIG;
    end else begin
      m_t = m_t + 1;
      if (m_t == BL) m_code = code_of(m_dig);
    end
  end

  always @(negedge clk) begin
    logic [NDIG-1:0] e_an;
    logic [6:0]      e_ext;
    int              zeros;
    if (chk_on) begin
      e_an  = (m_t >= BL) ? ~(4'b0001 << m_dig) : 4'hF;
      e_ext = (m_t >= BL) ? m_code : 7'h40;
      checks += 3;
      if (an_n !== e_an) begin
        failures++;
        $display("FAIL model_an t=%0t got=%h exp=%h", $time, an_n, e_an);
      end
      if (ext_out !== e_ext) begin
        failures++;
        $display("FAIL model_ext t=%0t got=%h exp=%h", $time, ext_out, e_ext);
      end
      if (int'(digit_sel) != m_dig) begin
        failures++;
        $display("FAIL model_sel t=%0t got=%0d exp=%0d", $time, digit_sel, m_dig);
      end
      zeros = 0;
      for (int k = 0; k < NDIG; k++) if (an_n[k] == 1'b0) zeros++;
      checks += 2;
      if (zeros > 1) begin
        failures++;
        $display("FAIL onehot_an t=%0t got=%h exp=at_most_one_low", $time, an_n);
      end
      if (an_n == 4'hF && ext_out != 7'h40) begin
        failures++;
        $display("FAIL dark_blank t=%0t got=%h exp=40", $time, ext_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dig(input int i, input logic [6:0] c);
    d_ext[7*i +: 7] = c;
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    d_ext = {7'h03, 7'h02, 7'h01, 7'h00};
    @(negedge clk);
    chk_on = 1'b1;
    step(2);
    // 1. reset state
    chk("rst_an", an_n, 4'hF);
    chk("rst_ext", ext_out, 7'h40);
    chk("rst_sel", digit_sel, 0);
    rst = 1'b0;
    step(1);
    chk("guard1_an", an_n, 4'hF);
    step(1);
    // 2. scan order
    chk("d0_an", an_n, 4'hE);
    chk("d0_ext", ext_out, 7'h00);
    step(12);
    chk("d1_an", an_n, 4'hD);
    chk("d1_ext", ext_out, 7'h01);
    step(12);
    chk("d2_an", an_n, 4'hB);
    chk("d2_ext", ext_out, 7'h02);
    step(12);
    chk("d3_an", an_n, 4'h7);
    chk("d3_ext", ext_out, 7'h03);
    step(10);
    chk("wrap_sel", digit_sel, 0);
    chk("wrap_an", an_n, 4'hF);
    step(2);
    chk("wrap_d0_an", an_n, 4'hE);
    // 3. mid-dwell change on digit 1
    step(12);
    chk("d1b_ext", ext_out, 7'h01);
    step(4);
    set_dig(1, 7'h15);
    step(4);
    chk("d1_hold_ext", ext_out, 7'h01);
    step(40);
    chk("d1_new_an", an_n, 4'hD);
    chk("d1_new_ext", ext_out, 7'h15);
    // 4. enable drop during digit 2
    step(15);
    chk("en_pre_an", an_n, 4'hB);
    en = 1'b0;
    step(1);
    chk("en_off_an", an_n, 4'hF);
    chk("en_off_ext", ext_out, 7'h40);
    chk("en_off_sel", digit_sel, 2);
    step(3);
    chk("en_hold_an", an_n, 4'hF);
    en = 1'b1;
    step(1);
    chk("en_guard_an", an_n, 4'hF);
    step(1);
    chk("en_resume_an", an_n, 4'hB);
    chk("en_resume_ext", ext_out, 7'h02);
    // 5. reset during digit 3
    step(14);
    chk("r_pre_an", an_n, 4'h7);
    rst = 1'b1;
    step(1);
    chk("r_mid_an", an_n, 4'hF);
    chk("r_mid_ext", ext_out, 7'h40);
    chk("r_mid_sel", digit_sel, 0);
    rst = 1'b0;
    step(2);
    chk("r_resume_an", an_n, 4'hE);
    // 6. leading-zero blanking
    d_ext = {7'h00, 7'h00, 7'h05, 7'h00};
    step(12);
    chk("lz_d1_an", an_n, 4'hD);
    chk("lz_d1_ext", ext_out, 7'h05);
    step(12);
    chk("lz_d2_an", an_n, 4'hB);
    chk("lz_d2_ext", ext_out, LZ ? 7'h40 : 7'h00);
    step(12);
    chk("lz_d3_an", an_n, 4'h7);
    chk("lz_d3_ext", ext_out, LZ ? 7'h40 : 7'h00);
    step(12);
    chk("lz_d0_an", an_n, 4'hE);
    chk("lz_d0_ext", ext_out, 7'h00);
    step(5);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
